// File: rtl/timer_ctrl_pkg.sv
// Purpose: shared types and default timing constants for the countdown-timer UI sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package timer_ctrl_pkg;

  typedef enum logic [1:0] {
    SET   = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } mode_t;

  typedef enum logic {
    FLD_MIN = 1'b0,
    FLD_SEC = 1'b1
  } field_t;

  // Plain-vector state codes for the mode register, identical to mode_t.
  localparam logic [1:0] ST_SET   = SET;
  localparam logic [1:0] ST_RUN   = RUN;
  localparam logic [1:0] ST_PAUSE = PAUSE;
  localparam logic [1:0] ST_DONE  = DONE;

  localparam int HOLD_MS_DEF   = 500;
  localparam int REPEAT_MS_DEF = 100;
  localparam int ALARM_MS_DEF  = 10000;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/btn_autorepeat.sv
// Purpose: turns a held button into a press pulse plus auto-repeat pulses paced by tick_1k.
// Latency: fire is combinational from rise/tick; the caller registers it.
// Backpressure: none; arm low suppresses firing and forgets any hold in progress.
//   clk, rst_n    : clock, synchronous active-low reset
//   level, rise   : debounced button level and its rising-edge strobe (from the caller's edge detect)
//   tick          : 1 kHz enable pulse
//   arm           : firing allowed this cycle
//   fire          : press or repeat event
module btn_autorepeat
  #(parameter int HOLD_TICKS   = 500,
    parameter int REPEAT_TICKS = 100,
    parameter int CNT_W        = 14)
  (input  logic clk,
   input  logic rst_n,
   input  logic level,
   input  logic rise,
   input  logic tick,
   input  logic arm,
   output logic fire);

  logic             active;     // a press seen while armed, still held
  logic             repeating;  // initial hold delay already served
  logic [CNT_W-1:0] cnt;        // ticks since the last press/repeat event
  logic             hit;

  always_comb begin
    hit = repeating ? (cnt == CNT_W'(REPEAT_TICKS - 1))
                    : (cnt == CNT_W'(HOLD_TICKS - 1));
  end

  // Requiring level here means a release never produces a trailing pulse.
  assign fire = arm & (rise | (active & level & tick & hit));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active    <= 1'b0;
      repeating <= 1'b0;
      cnt       <= '0;
    end else if (!level || !arm) begin
      active    <= 1'b0;
      repeating <= 1'b0;
      cnt       <= '0;
    end else if (rise) begin
      active    <= 1'b1;
      repeating <= 1'b0;
      cnt       <= '0;
    end else if (active && tick) begin
      if (hit) begin
        repeating <= 1'b1;
        cnt       <= '0;
      end else if (cnt != '1) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/timer_mode_ctrl.sv
// Purpose: UI sequencer for the countdown timer: button levels -> timer command pulses, SET/RUN/PAUSE/DONE mode.
// Latency: every output registered, one clk after the causing input.
// Backpressure: none; commands are single-cycle pulses the timer core must accept.
//   clk, rst_n, tick_1k                  : clock, synchronous active-low reset, 1 kHz enable
//   btn_mode/btn_ss/btn_up/btn_down      : debounced button levels
//   minutes, seconds                     : timer readback for zero detect
//   tmr_start/stop/reset/inc_min/inc_sec : command pulses; tmr_inc = adjust direction (1 up)
//   tmr_en, field_sel, mode, alarm       : count enable, selected field, current mode, alarm
module timer_mode_ctrl
  import timer_ctrl_pkg::*;
  #(parameter int HOLD_MS   = HOLD_MS_DEF,
    parameter int REPEAT_MS = REPEAT_MS_DEF,
    parameter int ALARM_MS  = ALARM_MS_DEF)
  (input  logic       clk,
   input  logic       rst_n,
   input  logic       tick_1k,
   input  logic       btn_mode,
   input  logic       btn_ss,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic [5:0] minutes,
   input  logic [5:0] seconds,
   output logic       tmr_start,
   output logic       tmr_stop,
   output logic       tmr_reset,
   output logic       tmr_inc_min,
   output logic       tmr_inc_sec,
   output logic       tmr_inc,
   output logic       tmr_en,
   output logic       field_sel,
   output logic [1:0] mode,
   output logic       alarm);

  localparam int CNT_W = $clog2(max3(HOLD_MS, REPEAT_MS, ALARM_MS) + 1);

  logic mode_prev, ss_prev, up_prev, down_prev;
  logic mode_rise, ss_rise, up_rise, down_rise, any_rise;
  logic clear_ev, clr_lock, arm, up_fire, down_fire;
  logic time_nz, run_seen, alarm_hit;
  logic [CNT_W-1:0] alarm_cnt;

  logic [1:0] mode_nx;
  logic field_nx, start_nx, stop_nx, reset_nx, imin_nx, isec_nx, inc_nx;

  assign mode_rise = btn_mode & ~mode_prev;
  assign ss_rise   = btn_ss   & ~ss_prev;
  assign up_rise   = btn_up   & ~up_prev;
  assign down_rise = btn_down & ~down_prev;
  assign any_rise  = mode_rise | ss_rise | up_rise | down_rise;

  // Both adjust buttons down with a fresh edge on either is the clear chord.
  assign clear_ev = btn_up & btn_down & (up_rise | down_rise);
  assign time_nz  = (|minutes) | (|seconds);
  assign alarm_hit = tick_1k & (alarm_cnt == CNT_W'(ALARM_MS - 1));

  // Up/down only act in SET, and only when no higher-priority event owns the cycle;
  // a press lost to a higher-priority event never starts a repeat later.
  assign arm = (mode == ST_SET) & ~clr_lock & ~clear_ev & ~ss_rise & ~mode_rise;

  btn_autorepeat #(.HOLD_TICKS(HOLD_MS), .REPEAT_TICKS(REPEAT_MS), .CNT_W(CNT_W)) u_rpt_up (
    .clk(clk), .rst_n(rst_n), .level(btn_up), .rise(up_rise), .tick(tick_1k),
    .arm(arm), .fire(up_fire));

  btn_autorepeat #(.HOLD_TICKS(HOLD_MS), .REPEAT_TICKS(REPEAT_MS), .CNT_W(CNT_W)) u_rpt_down (
    .clk(clk), .rst_n(rst_n), .level(btn_down), .rise(down_rise), .tick(tick_1k),
    .arm(arm), .fire(down_fire));

  always_comb begin
    mode_nx  = mode;
    field_nx = field_sel;
    start_nx = 1'b0;
    stop_nx  = 1'b0;
    reset_nx = 1'b0;
    imin_nx  = 1'b0;
    isec_nx  = 1'b0;
    inc_nx   = tmr_inc;
    if (clear_ev) begin
      reset_nx = 1'b1;
      mode_nx  = ST_SET;
      field_nx = FLD_MIN;
    end else begin
      case (mode)
        ST_SET: begin
          if (ss_rise) begin
            if (time_nz) begin
              start_nx = 1'b1;
              mode_nx  = ST_RUN;
            end
          end else if (mode_rise) begin
            field_nx = ~field_sel;
          end else if (up_fire || down_fire) begin
            imin_nx = (field_sel == FLD_MIN);
            isec_nx = (field_sel == FLD_SEC);
            inc_nx  = up_fire;
          end
        end
        ST_RUN: begin
          if (ss_rise) begin
            stop_nx = 1'b1;
            mode_nx = ST_PAUSE;
          end else if (run_seen && !time_nz) begin
            // run_seen skips the first RUN cycle, before the core has counted.
            mode_nx = ST_DONE;
          end
        end
        ST_PAUSE: begin
          if (ss_rise) begin
            start_nx = 1'b1;
            mode_nx  = ST_RUN;
          end else if (mode_rise) begin
            mode_nx = ST_SET;
          end
        end
        default: begin
          if (any_rise || alarm_hit) begin
            reset_nx = 1'b1;
            mode_nx  = ST_SET;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_prev   <= 1'b0;
      ss_prev     <= 1'b0;
      up_prev     <= 1'b0;
      down_prev   <= 1'b0;
      clr_lock    <= 1'b0;
      run_seen    <= 1'b0;
      alarm_cnt   <= '0;
      mode        <= ST_SET;
      field_sel   <= FLD_MIN;
      tmr_start   <= 1'b0;
      tmr_stop    <= 1'b0;
      tmr_reset   <= 1'b0;
      tmr_inc_min <= 1'b0;
      tmr_inc_sec <= 1'b0;
      tmr_inc     <= 1'b0;
      tmr_en      <= 1'b0;
      alarm       <= 1'b0;
    end else begin
      mode_prev   <= btn_mode;
      ss_prev     <= btn_ss;
      up_prev     <= btn_up;
      down_prev   <= btn_down;
      if (clear_ev)
        clr_lock <= 1'b1;
      else if (!btn_up && !btn_down)
        clr_lock <= 1'b0;
      run_seen    <= (mode == ST_RUN);
      if (mode != ST_DONE || mode_nx != mode)
        alarm_cnt <= '0;
      else if (tick_1k && alarm_cnt != '1)
        alarm_cnt <= alarm_cnt + CNT_W'(1);
      mode        <= mode_nx;
      field_sel   <= field_nx;
      tmr_start   <= start_nx;
      tmr_stop    <= stop_nx;
      tmr_reset   <= reset_nx;
      tmr_inc_min <= imin_nx;
      tmr_inc_sec <= isec_nx;
      tmr_inc     <= inc_nx;
      tmr_en      <= (mode_nx == ST_RUN);
      alarm       <= (mode_nx == ST_DONE);
    end
  end

endmodule

// File: tb/tb_timer_mode_ctrl.sv
// Purpose: self-checking bench for timer_mode_ctrl with randomized tick spacing and readback values.
// Latency: outputs sampled 1 time unit after each clk edge.
// Backpressure: n/a.
module tb_timer_mode_ctrl;

  localparam int HOLD   = 500;
  localparam int REPEAT = 100;
  localparam int ALARM  = 10000;

  // Pulse vector order: {start, stop, reset, inc_min, inc_sec}
  localparam logic [4:0] P_NONE  = 5'b00000;
  localparam logic [4:0] P_START = 5'b10000;
  localparam logic [4:0] P_STOP  = 5'b01000;
  localparam logic [4:0] P_RESET = 5'b00100;
  localparam logic [4:0] P_IMIN  = 5'b00010;
  localparam logic [4:0] P_ISEC  = 5'b00001;

  logic       clk = 1'b0;
  logic       rst_n, tick_1k, btn_mode, btn_ss, btn_up, btn_down;
  logic [5:0] minutes, seconds;
  logic       tmr_start, tmr_stop, tmr_reset, tmr_inc_min, tmr_inc_sec, tmr_inc, tmr_en;
  logic       field_sel, alarm;
  logic [1:0] mode;
  logic [4:0] pulses;

  int checks = 0;
  int errors = 0;
  int rep_seen;
  int n_ticks;
  int gap;

  assign pulses = {tmr_start, tmr_stop, tmr_reset, tmr_inc_min, tmr_inc_sec};

  always #5 clk = ~clk;

  timer_mode_ctrl dut (
    .clk(clk), .rst_n(rst_n), .tick_1k(tick_1k),
    .btn_mode(btn_mode), .btn_ss(btn_ss), .btn_up(btn_up), .btn_down(btn_down),
    .minutes(minutes), .seconds(seconds),
    .tmr_start(tmr_start), .tmr_stop(tmr_stop), .tmr_reset(tmr_reset),
    .tmr_inc_min(tmr_inc_min), .tmr_inc_sec(tmr_inc_sec), .tmr_inc(tmr_inc),
    .tmr_en(tmr_en), .field_sel(field_sel), .mode(mode), .alarm(alarm));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference rule: with the button held since a press, the n-th tick after the press
  // repeats when the hold delay has elapsed and n lands on the repeat period grid.
  function automatic bit rep_due(input int n);
    return (n >= HOLD) && (((n - HOLD) % REPEAT) == 0);
  endfunction

  // Tick a held adjust button from tick count n_from+1 to n_to, checking every cycle.
  task automatic tick_hold(input int n_from, input int n_to, input logic [4:0] p);
    for (int n = n_from + 1; n <= n_to; n++) begin
      gap = $urandom_range(0, 1);
      repeat (gap) begin
        step();
        chk("hold_gap", pulses, P_NONE);
      end
      tick_1k = 1'b1;
      step();
      tick_1k = 1'b0;
      chk("hold_tick", pulses, rep_due(n) ? p : P_NONE);
      if (rep_due(n) && pulses == p) rep_seen++;
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_mode"},   mode,      0);
    chk({tag, "_field"},  field_sel, 0);
    chk({tag, "_pulses"}, pulses,    P_NONE);
    chk({tag, "_inc"},    tmr_inc,   0);
    chk({tag, "_en"},     tmr_en,    0);
    chk({tag, "_alarm"},  alarm,     0);
  endtask

  initial begin
    rst_n = 1'b0; tick_1k = 1'b0;
    btn_mode = 1'b0; btn_ss = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    minutes = 6'd0; seconds = 6'd0;
    repeat (3) step();
    chk_reset_state("reset");
    rst_n = 1'b1;
    step();
    chk("post_reset_pulses", pulses, P_NONE);

    // Three taps of up in SET, minutes field.
    rep_seen = 0;
    for (int k = 0; k < 3; k++) begin
      btn_up = 1'b1;
      step();
      chk("tap_pulse", pulses, P_IMIN);
      chk("tap_dir", tmr_inc, 1);
      if (pulses == P_IMIN) rep_seen++;
      repeat ($urandom_range(1, 6)) begin
        step();
        chk("tap_held", pulses, P_NONE);
      end
      btn_up = 1'b0;
      repeat ($urandom_range(1, 6)) begin
        step();
        chk("tap_rel", pulses, P_NONE);
        chk("tap_mode", mode, 0);
      end
    end
    chk("tap_total", rep_seen, 3);

    // Hold up for 1000 ticks, then release with ticks still running.
    btn_up = 1'b1;
    step();
    chk("hold_press", pulses, P_IMIN);
    rep_seen = 1;
    tick_hold(0, 1000, P_IMIN);
    chk("hold_total", rep_seen, 7);
    btn_up = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick_1k = i[0];
      step();
      chk("hold_after_rel", pulses, P_NONE);
    end
    tick_1k = 1'b0;

    // Field select and down on seconds.
    btn_mode = 1'b1; step();
    chk("field_to_sec", field_sel, 1);
    chk("field_no_pulse", pulses, P_NONE);
    btn_mode = 1'b0; step();
    btn_down = 1'b1; step();
    chk("down_sec", pulses, P_ISEC);
    chk("down_dir", tmr_inc, 0);
    btn_down = 1'b0; step();
    chk("down_rel", pulses, P_NONE);
    btn_mode = 1'b1; step();
    chk("field_to_min", field_sel, 0);
    btn_mode = 1'b0; step();

    // Start attempt with 00:00 is ignored; nonzero time starts.
    btn_ss = 1'b1; step();
    chk("zero_start_pulses", pulses, P_NONE);
    chk("zero_start_mode", mode, 0);
    btn_ss = 1'b0; step();
    minutes = 6'($urandom_range(0, 59));
    seconds = 6'($urandom_range(1, 59));
    btn_ss = 1'b1; step();
    chk("start_pulse", pulses, P_START);
    chk("start_mode", mode, 1);
    chk("start_en", tmr_en, 1);
    btn_ss = 1'b0; step();
    chk("run_pulse_once", pulses, P_NONE);
    chk("run_mode", mode, 1);

    // RUN ignores up and mode buttons.
    btn_up = 1'b1; step();
    chk("run_up_ignored", pulses, P_NONE);
    btn_up = 1'b0; step();
    btn_mode = 1'b1; step();
    chk("run_mode_ignored", mode, 1);
    btn_mode = 1'b0; step();

    // Pause and resume.
    btn_ss = 1'b1; step();
    chk("stop_pulse", pulses, P_STOP);
    chk("pause_mode", mode, 2);
    chk("pause_en", tmr_en, 0);
    btn_ss = 1'b0; step();
    btn_up = 1'b1; step();
    chk("pause_up_ignored", pulses, P_NONE);
    btn_up = 1'b0; step();
    btn_ss = 1'b1; step();
    chk("resume_pulse", pulses, P_START);
    chk("resume_mode", mode, 1);
    chk("resume_en", tmr_en, 1);
    btn_ss = 1'b0; step(); step();

    // Count reaches zero.
    minutes = 6'd0; seconds = 6'd0;
    step();
    chk("done_mode", mode, 3);
    chk("done_alarm", alarm, 1);
    chk("done_en", tmr_en, 0);

    // Alarm times out after ALARM ticks with no buttons.
    n_ticks = 0;
    while (n_ticks < ALARM) begin
      gap = $urandom_range(0, 1);
      repeat (gap) begin
        step();
        chk("alarm_gap_mode", mode, 3);
      end
      tick_1k = 1'b1;
      n_ticks++;
      step();
      tick_1k = 1'b0;
      if (n_ticks < ALARM) begin
        chk("alarm_wait_mode", mode, 3);
        chk("alarm_wait_pulses", pulses, P_NONE);
      end else begin
        chk("alarm_to_mode", mode, 0);
        chk("alarm_to_pulse", pulses, P_RESET);
        chk("alarm_to_alarm", alarm, 0);
      end
    end
    step();
    chk("alarm_to_once", pulses, P_NONE);

    // Enter DONE again and leave it with a mode press after 50 ticks.
    seconds = 6'($urandom_range(1, 59));
    btn_ss = 1'b1; step();
    chk("start2_pulse", pulses, P_START);
    btn_ss = 1'b0; step(); step();
    seconds = 6'd0;
    step();
    chk("done2_mode", mode, 3);
    for (int i = 0; i < 50; i++) begin
      tick_1k = 1'b1; step();
      tick_1k = 1'b0; step();
      chk("done2_wait", mode, 3);
    end
    btn_mode = 1'b1; step();
    chk("done2_exit_pulse", pulses, P_RESET);
    chk("done2_exit_mode", mode, 0);
    chk("done2_exit_alarm", alarm, 0);
    btn_mode = 1'b0; step();

    // Clear chord while up repeats: down and start/stop rise together.
    seconds = 6'd7;
    btn_up = 1'b1; step();
    chk("clr_up_press", pulses, P_IMIN);
    rep_seen = 0;
    tick_hold(0, 550, P_IMIN);
    chk("clr_up_reps", rep_seen, 1);
    btn_down = 1'b1; btn_ss = 1'b1; step();
    chk("clr_pulse", pulses, P_RESET);
    chk("clr_mode", mode, 0);
    btn_ss = 1'b0; step();
    chk("clr_no_start", pulses, P_NONE);
    chk("clr_mode_hold", mode, 0);
    for (int i = 0; i < 150; i++) begin
      tick_1k = 1'b1; step();
      tick_1k = 1'b0; step();
      chk("clr_disarmed", pulses, P_NONE);
    end
    btn_up = 1'b0; btn_down = 1'b0; step();

    // Clear chord from RUN.
    btn_ss = 1'b1; step();
    chk("start3_mode", mode, 1);
    btn_ss = 1'b0; step(); step();
    btn_up = 1'b1; btn_down = 1'b1; step();
    chk("clr_run_pulse", pulses, P_RESET);
    chk("clr_run_mode", mode, 0);
    chk("clr_run_en", tmr_en, 0);
    btn_up = 1'b0; btn_down = 1'b0; step();

    // Reset in the middle of a repeat on the seconds field.
    btn_mode = 1'b1; step();
    chk("rst_field_sec", field_sel, 1);
    btn_mode = 1'b0; step();
    btn_up = 1'b1; step();
    chk("rst_up_press", pulses, P_ISEC);
    rep_seen = 0;
    tick_hold(0, 520, P_ISEC);
    chk("rst_up_reps", rep_seen, 1);
    rst_n = 1'b0; btn_up = 1'b0; step();
    chk_reset_state("midrep_reset");
    rst_n = 1'b1; step();
    chk("after_reset_pulses", pulses, P_NONE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
